// File: rtl/fp16_pkg.sv
// Shared constants, state encoding and compare helper for the half-precision sequential unit.
// No logic of its own; used by every file of the unit.
// Opcodes, OFUF codes and compare codes match the operand-interface encoding seen by initiators.
package fp16_pkg;

    // Operation select on the operand interface
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_CMP = 2'd3;

    // OFUF status codes
    localparam logic [1:0] OFUF_OK  = 2'b00;
    localparam logic [1:0] OFUF_OV  = 2'b10;
    localparam logic [1:0] OFUF_UF  = 2'b01;
    localparam logic [1:0] OFUF_INV = 2'b11;

    // compResult codes {gt,eq,lt}
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    // Frequently used half-precision constants
    localparam logic [15:0] FP16_ONE          = 16'h3C00;
    localparam logic [15:0] FP16_INF          = 16'h7C00;
    localparam logic [15:0] FP16_THREE_HALVES = 16'h3E00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } seqState_e;

    // Sign-magnitude ordering of two halves; +0 and -0 compare equal.
    function automatic logic [2:0] cmpHalf(input logic [15:0] x, input logic [15:0] y);
        logic [2:0] code;
        if (x[14:0] == 15'd0 && y[14:0] == 15'd0) begin
            code = CMP_EQ;
        end else if (x[15] != y[15]) begin
            code = x[15] ? CMP_LT : CMP_GT;
        end else if (x[14:0] == y[14:0]) begin
            code = CMP_EQ;
        end else if ((x[14:0] > y[14:0]) ^ x[15]) begin
            // larger magnitude wins for positives, loses for negatives
            code = CMP_GT;
        end else begin
            code = CMP_LT;
        end
        return code;
    endfunction

endpackage

// File: rtl/fp16_seq_unit_if.sv
// Operand/result bundle between an initiator FSM and the half-precision sequential unit.
// Latency and flow control are defined by the responder: start pulse in, sticky done out.
// No backpressure; the initiator holds off start until it wants a new operation.
// Ports: start/xOp/yOp/opcode from initiator; result/compResult/OFUF/done from responder.
interface fp16_seq_unit_if;
    logic        start;
    logic [15:0] xOp;
    logic [15:0] yOp;
    logic [1:0]  opcode;
    logic [15:0] result;
    logic [2:0]  compResult;
    logic [1:0]  OFUF;
    logic        done;

    modport master (
        output start, xOp, yOp, opcode,
        input  result, compResult, OFUF, done
    );

    modport slave (
        input  start, xOp, yOp, opcode,
        output result, compResult, OFUF, done
    );
endinterface

// File: rtl/fp16_mant_mul_seq.sv
// Sequential shift-add multiplier for two SIG_W-bit significands into a 2*SIG_W-bit product.
// Latency: one load cycle plus SIG_W step cycles; product valid after the last step.
// No backpressure; the controlling FSM decides when to load and when to step.
// Ports: clk, reset (sync, active-low), load, step, multiplicand, multiplier, product.
module fp16_mant_mul_seq #(
    parameter int SIG_W = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [SIG_W-1:0]     multiplicand,
    input  logic [SIG_W-1:0]     multiplier,
    output logic [2*SIG_W-1:0]   product
);
    logic [2*SIG_W-1:0] mcand;
    logic [SIG_W-1:0]   mplier;
    logic [2*SIG_W-1:0] prodQ;

    // Each step consumes the multiplier LSB and moves the multiplicand
    // one place left, so step k adds multiplicand*2^k when bit k is set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            prodQ  <= '0;
        end else if (load) begin
            mcand  <= {{SIG_W{1'b0}}, multiplicand};
            mplier <= multiplier;
            prodQ  <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                prodQ <= prodQ + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign product = prodQ;
endmodule

// File: rtl/fp16_seq_unit.sv
// Multi-cycle half-precision multiply/compare responder behind the xOp/yOp/opcode/start/done protocol.
// Latency: compare, add/sub (invalid) and special-operand multiply 1 cycle; normal multiply 13 cycles.
// No backpressure; a start in any state aborts in-flight work and restarts; done is sticky until next start.
// Ports: clk, reset (sync, active-low), bus (slave side: start/xOp/yOp/opcode in, result/compResult/OFUF/done out).
module fp16_seq_unit
    import fp16_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int BIAS  = 15
) (
    input  logic           clk,
    input  logic           reset,
    fp16_seq_unit_if.slave bus
);
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int ESUM_W = EXP_W + 2;
    localparam int CNT_W  = $clog2(SIG_W);

    localparam logic [EXP_W-1:0]         EXP_SPECIAL = '1;
    localparam logic signed [ESUM_W-1:0] BIAS_S      = ESUM_W'(BIAS);
    localparam logic signed [ESUM_W-1:0] EXP_TOP     = ESUM_W'((1 << EXP_W) - 2);
    localparam logic signed [ESUM_W-1:0] EXP_MIN     = ESUM_W'(1);
    localparam logic [CNT_W-1:0]         LAST_STEP   = CNT_W'(MAN_W);

    // Operand fields straight from the bus; only meaningful on the start cycle
    logic             xSign, ySign;
    logic [EXP_W-1:0] xExp, yExp;
    logic [MAN_W-1:0] xMan, yMan;

    assign xSign = bus.xOp[EXP_W+MAN_W];
    assign ySign = bus.yOp[EXP_W+MAN_W];
    assign xExp  = bus.xOp[MAN_W +: EXP_W];
    assign yExp  = bus.yOp[MAN_W +: EXP_W];
    assign xMan  = bus.xOp[MAN_W-1:0];
    assign yMan  = bus.yOp[MAN_W-1:0];

    seqState_e                 state, stateNxt;
    logic [CNT_W-1:0]          cnt, cntNxt;
    logic                      signQ, signNxt;
    logic signed [ESUM_W-1:0]  expSumQ, expSumNxt;
    logic [15:0]               resultQ, resultNxt;
    logic [2:0]                compResultQ, compResultNxt;
    logic [1:0]                ofufQ, ofufNxt;
    logic                      doneQ, doneNxt;

    logic                      mulLoad, mulStep;
    logic [PROD_W-1:0]         product;

    // Normalisation view of the product
    logic                      prodTop;
    logic signed [ESUM_W-1:0]  expAdj;
    logic [MAN_W-1:0]          mant;
    logic                      unusedProdLsbs;

    fp16_mant_mul_seq #(
        .SIG_W(SIG_W)
    ) uMantMul (
        .clk          (clk),
        .reset        (reset),
        .load         (mulLoad),
        .step         (mulStep),
        .multiplicand ({1'b1, xMan}),
        .multiplier   ({1'b1, yMan}),
        .product      (product)
    );

    // Product of two [1,2) significands lies in [1,4): top bit set means
    // the value is >= 2, so drop one more LSB and bump the exponent.
    assign prodTop = product[PROD_W-1];
    assign expAdj  = expSumQ + {{(ESUM_W-1){1'b0}}, prodTop};
    assign mant    = prodTop ? product[PROD_W-2 -: MAN_W] : product[PROD_W-3 -: MAN_W];
    // Bits below the kept mantissa are discarded: round toward zero
    assign unusedProdLsbs = ^product[PROD_W-MAN_W-3:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            signQ       <= 1'b0;
            expSumQ     <= '0;
            resultQ     <= 16'h0000;
            compResultQ <= 3'b000;
            ofufQ       <= OFUF_OK;
            doneQ       <= 1'b0;
        end else begin
            state       <= stateNxt;
            cnt         <= cntNxt;
            signQ       <= signNxt;
            expSumQ     <= expSumNxt;
            resultQ     <= resultNxt;
            compResultQ <= compResultNxt;
            ofufQ       <= ofufNxt;
            doneQ       <= doneNxt;
        end
    end

    always_comb begin
        stateNxt      = state;
        cntNxt        = cnt;
        signNxt       = signQ;
        expSumNxt     = expSumQ;
        resultNxt     = resultQ;
        compResultNxt = compResultQ;
        ofufNxt       = ofufQ;
        doneNxt       = doneQ;
        mulLoad       = 1'b0;
        mulStep       = 1'b0;

        if (bus.start) begin
            // A start always wins: operands are taken from the bus this cycle
            // and any multiply in progress is abandoned.
            stateNxt = DONE;
            doneNxt  = 1'b1;
            cntNxt   = '0;
            case (bus.opcode)
                OP_CMP: begin
                    compResultNxt = cmpHalf(bus.xOp, bus.yOp);
                    ofufNxt       = OFUF_OK;
                end
                OP_MUL: begin
                    signNxt   = xSign ^ ySign;
                    expSumNxt = ESUM_W'(xExp) + ESUM_W'(yExp) - BIAS_S;
                    if (xExp == '0 || yExp == '0) begin
                        // Zeros and subnormals flush to signed zero
                        resultNxt = {xSign ^ ySign, {(EXP_W+MAN_W){1'b0}}};
                        ofufNxt   = OFUF_OK;
                    end else if (xExp == EXP_SPECIAL || yExp == EXP_SPECIAL) begin
                        resultNxt = {xSign ^ ySign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        ofufNxt   = OFUF_OV;
                    end else begin
                        stateNxt = MUL;
                        doneNxt  = 1'b0;
                        mulLoad  = 1'b1;
                    end
                end
                default: begin
                    // add/sub report an invalid opcode with a zero result
                    resultNxt = 16'h0000;
                    ofufNxt   = OFUF_INV;
                end
            endcase
        end else begin
            case (state)
                MUL: begin
                    mulStep = 1'b1;
                    if (cnt == LAST_STEP) begin
                        stateNxt = NORM;
                    end else begin
                        cntNxt = cnt + 1'b1;
                    end
                end
                NORM: begin
                    if (expAdj > EXP_TOP) begin
                        resultNxt = {signQ, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        ofufNxt   = OFUF_OV;
                    end else if (expAdj < EXP_MIN) begin
                        resultNxt = {signQ, {(EXP_W+MAN_W){1'b0}}};
                        ofufNxt   = OFUF_UF;
                    end else begin
                        resultNxt = {signQ, expAdj[EXP_W-1:0], mant};
                        ofufNxt   = OFUF_OK;
                    end
                    doneNxt  = 1'b1;
                    stateNxt = DONE;
                end
                default: begin
                    // IDLE and DONE simply hold their outputs
                end
            endcase
        end
    end

    assign bus.result     = resultQ;
    assign bus.compResult = compResultQ;
    assign bus.OFUF       = ofufQ;
    // Mask so an initiator never sees the previous op's done in its start cycle
    assign bus.done       = doneQ & ~bus.start;

endmodule

// File: doc/fp16_seq_unit.md
Name: fp16_seq_unit

Overview:
Responder side of the half-precision FPU operand interface. It accepts operands and an opcode on a one-cycle start pulse, computes the result over multiple cycles, and raises a sticky done with the result and the OFUF/compare flags.
It is a drop-in multi-cycle arithmetic engine behind the same xOp/yOp/opcode/start/done protocol that the sequencing FSMs (e.g. inverse-sqrt) drive.
It supports multiply and compare. Add and subtract are flagged as invalid.

Parameters:
EXP_W, 5, exponent field width
MAN_W, 10, stored mantissa width (hidden bit added internally)
BIAS, 15, exponent bias

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
start  input  1  one-cycle pulse; samples xOp/yOp/opcode
xOp  input  16  operand X (IEEE half)
yOp  input  16  operand Y (IEEE half)
opcode  input  2  0 add, 1 sub, 2 mul, 3 compare
result  output  16  registered result
compResult  output  3  {gt,eq,lt} of X vs Y
OFUF  output  2  00 ok, 10 overflow, 01 underflow, 11 invalid opcode
done  output  1  result valid (sticky)

Behaviour:
- Reset (reset==0 at edge): state IDLE; result 16'h0000, compResult 3'b000, OFUF 2'b00, done_q 0. Reset has priority over start and takes effect mid-operation; in-flight work is discarded.
- done = done_q AND NOT start (combinational mask). This guarantees an initiator never sees a stale done during its start cycle.
- done_q stays high until the next accepted start or reset.
- Start accepted in any state, including mid-multiply (abort and restart). Operands are latched on the start edge; later changes on xOp/yOp/opcode are ignored. The start edge clears done_q.
- States: IDLE, MUL, NORM, DONE.
- opcode 3 (compare), start edge:
  - compResult set from latched operands.
  - Sign-magnitude ordering; +0 == -0.
  - Codes: 100 gt, 010 eq, 001 lt.
  - OFUF 00; result unchanged; done_q 1 after the same edge. Latency 1.
- opcode 0/1, start edge: OFUF 11, result 0x0000, done_q 1. Latency 1.
- opcode 2 (multiply):
  - Start edge: sign = xs^ys; exp_sum = ex + ey - BIAS held as 7-bit signed; mantissas {1,man} loaded; counter = 0; state MUL.
  - Zero or subnormal (exp==0) on either operand: flush to a signed-zero result, OFUF 00, skip to DONE (latency 1).
  - Inf/NaN on either operand (exp==31): OFUF 10, result {sign,0x7C00[14:0]}, DONE.
  - MUL: one shift-add step per cycle over 11 cycles (counter 0..10) into a 22-bit product. On counter==10, go to NORM.
  - NORM:
    - If product[21], take mantissa = product[20:11] and increment exp.
    - Else take mantissa = product[19:10].
    - Truncate (round toward zero).
    - Biased exp > 30: OFUF 10, result {sign,5'h1F,10'h0}.
    - Biased exp < 1: OFUF 01, result {sign,15'h0}.
    - Else: result {sign,exp[4:0],mant}, OFUF 00.
    - Set done_q; go to DONE.
  - Latency: done visible 13 cycles after the start edge (1 load + 11 MUL + 1 NORM).
- DONE holds all outputs until the next start.
- compResult is only updated by compare ops. OFUF and result are updated by every op.

Decomposition:
- Shared package fp16_pkg:
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_CMP
  - OFUF codes OFUF_OK/OFUF_OV/OFUF_UF/OFUF_INV
  - compare codes CMP_GT/CMP_EQ/CMP_LT
  - constants FP16_ONE 16'h3C00, FP16_INF 16'h7C00, FP16_THREE_HALVES 16'h3E00
  - state encoding
- One sub-module: fp16_mant_mul_seq, an 11-bit x 11-bit shift-add multiplier with load, step, and 22-bit product output, driven by the top FSM.

Test Plan:
- mul 0x3C00*0x3C00 -> done low for 12 cycles, high at cycle 13; result 0x3C00, OFUF 00.
- mul 0x3E00*0xC000 (1.5*-2) -> result 0xC200, OFUF 00; done stays high 5 cycles with start low; done masked low in the cycle start is next asserted.
- mul 0x7800*0x7800 -> OFUF 10, result 0x7C00. mul 0x0400*0x0400 -> OFUF 01, result 0x0000. mul 0x0000*0x4000 -> result 0x0000, latency 1.
- cmp 0x3E00 vs 0x3C00 -> compResult 100, done after 1 cycle. cmp 0x8000 vs 0x0000 -> 010. cmp 0xC000 vs 0x3C00 -> 001. opcode 1 -> OFUF 11.
- mul 0x3E00*0x4000 started, then start re-pulsed at cycle 5 with 0x4000*0x4200 -> done never rises for the first op; done 13 cycles after the second start, result 0x4600.
- reset low at cycle 7 of a multiply -> after that edge result 0x0000, OFUF 00, compResult 000, done 0; done stays 0 without a new start.
